ps2_mouse_device: RTL and testbench
===================================

Name: ps2_mouse_device

Overview:
- Device-side PS/2 mouse emulator: the opposite end of the host-side mouse interface. It acts as the responder and clock master of the PS/2 link.
- Receives host-to-device command bytes, answers with the required ACK/status bytes, and in stream mode sends standard 3-byte movement packets built from local inputs.
- Used as a bench/board stand-in for a physical mouse, so the host interface can be exercised on-chip.

Parameters:
- CLK_HALF, 2000, system clocks per PS/2 clock half-period (40 us at 50 MHz).
- INHIBIT_MIN, 5000, system clocks the host must hold ps2c low to qualify as a request-to-send (100 us).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-low.
- ps2c  inout  1  PS/2 clock, open-drain: drive 0 or Z, never 1.
- ps2d  inout  1  PS/2 data, open-drain: drive 0 or Z, never 1.
- x_mov  in  9  two's-complement X movement.
- y_mov  in  9  two's-complement Y movement.
- btn  in  3  buttons {middle,right,left}.
- pkt_req  in  1  one-cycle request to send a packet.
- busy  out  1  high while not in IDLE.
- streaming  out  1  stream mode enabled.
- cmd_data  out  8  last received command byte.
- cmd_tick  out  1  one-cycle pulse when cmd_data is updated.
- err_tick  out  1  one-cycle pulse on rx parity/stop error or tx abort.

Behaviour:
- Reset (reset=0), applied asynchronously:
  - State IDLE; both lines released (Z).
  - busy=0, streaming=0, cmd_data=0, cmd_tick=0, err_tick=0.
  - Reset mid-frame releases the lines immediately; no partial byte resumes.
- Inputs: ps2c and ps2d pass through 2-flop synchronizers. All line decisions use the synchronized values.
- Bit timing: one bit = CLK_HALF cycles clock released (high), then CLK_HALF cycles clock driven low. Minimum inter-byte gap is 2*CLK_HALF cycles with both lines released.
- Device-to-host byte (11 bits):
  - Order: start 0, data[0..7] LSB first, odd parity, stop 1.
  - Data bit is set at the start of each high half; the host samples on the falling edge.
  - At mid high-phase the device samples ps2c. If it reads 0, the host has inhibited: release both lines, abort the byte and the rest of the queued sequence, pulse err_tick, go to INHIB.
- Request-to-send detection (IDLE or INHIB):
  - Count cycles while ps2c=0.
  - Count reaches INHIBIT_MIN, then ps2c returns 1 with ps2d=0: wait CLK_HALF, enter RX.
  - ps2c returns 1 with ps2d=1, or before the count is reached: back to IDLE.
- RX:
  - Generate 10 clock pulses. Sample ps2d at mid high-phase: 8 data bits LSB first, then parity, then stop.
  - 11th pulse: device drives ps2d=0 (line ACK) for the full pulse, then releases.
  - Parity must be odd and stop must be 1. On error: pulse err_tick and reply 0xFE; cmd_data/cmd_tick are not updated.
- Command handling on a good byte (cmd_tick pulses the cycle after the ACK pulse):
  - 0xF4: reply 0xFA; set streaming=1.
  - 0xF5: reply 0xFA; clear streaming.
  - 0xFF: reply 0xFA, 0xAA, 0x00; clear streaming.
  - Any other byte: reply 0xFA.
  - A streaming change takes effect when the 0xFA transmission starts.
- Packet:
  - Accepted only in IDLE with streaming=1; pkt_req otherwise ignored (not queued).
  - Inputs are latched on the accept cycle.
  - Byte1 = {2'b00, y[8], x[8], 1'b1, btn}; byte2 = x[7:0]; byte3 = y[7:0].
  - Sent with inter-byte gaps, then IDLE.
- Simultaneous events:
  - Host RTS always wins over pkt_req.
  - pkt_req in the same cycle as the end of a reply is ignored.
- States: IDLE, INHIB, RX_WAIT, RX, TX_BYTE, TX_GAP.
  - TX sequencer index 0..2 selects the reply/packet byte.
  - busy=1 in every state except IDLE.

Test Plan:
- Tests use CLK_HALF=4, INHIBIT_MIN=20.
- Host RTS, then sends 0xF4 with correct parity → device ACKs on the 11th clock; cmd_data=0xF4 with cmd_tick pulse; host receives 0xFA (parity 1); streaming=1.
- streaming=1, pkt_req with x_mov=9'h1F0, y_mov=9'h005, btn=3'b001 → bytes 0x19, 0xF0, 0x05 with odd parity; busy returns 0.
- streaming=0, pkt_req → no line activity; busy stays 0.
- Host sends 0xFF → replies 0xFA, 0xAA, 0x00 in order; streaming=0.
- Host sends 0xF4 with wrong parity → err_tick pulse; reply 0xFE; cmd_tick not asserted.
- Host holds ps2c low mid-way through packet byte 2 → err_tick; lines released; after RTS with 0xF5 the device replies 0xFA and streaming=0.
- Assert reset mid-RX → both lines Z within 1 cycle; all outputs at reset values.

Source files
------------

// File: rtl/ps2_mouse_device_if.sv
// ps2_mouse_device_if: local-side signals of the PS/2 mouse emulator.
//   x_mov, y_mov : 9-bit two's-complement movement (master -> device)
//   btn          : buttons {middle,right,left}      (master -> device)
//   pkt_req      : one-cycle packet request         (master -> device)
//   busy         : device not idle                  (device -> master)
//   streaming    : stream mode enabled              (device -> master)
//   cmd_data     : last good command byte           (device -> master)
//   cmd_tick     : pulse when cmd_data updates      (device -> master)
//   err_tick     : pulse on rx error or tx abort    (device -> master)
interface ps2_mouse_device_if;
    logic [8:0] x_mov;
    logic [8:0] y_mov;
    logic [2:0] btn;
    logic       pkt_req;
    logic       busy;
    logic       streaming;
    logic [7:0] cmd_data;
    logic       cmd_tick;
    logic       err_tick;

    modport master (
        output x_mov, y_mov, btn, pkt_req,
        input  busy, streaming, cmd_data, cmd_tick, err_tick
    );

    modport slave (
        input  x_mov, y_mov, btn, pkt_req,
        output busy, streaming, cmd_data, cmd_tick, err_tick
    );
endinterface

// File: rtl/ps2_mouse_device.sv
// ps2_mouse_device: device-side PS/2 mouse emulator. Acts as PS/2 clock
// master, receives host commands, replies with ACK/status bytes and in
// stream mode sends 3-byte movement packets.
//   clk   : system clock
//   reset : asynchronous reset, active-low
//   ps2c  : PS/2 clock, open-drain (drives 0 or Z only)
//   ps2d  : PS/2 data, open-drain (drives 0 or Z only)
//   mif   : local-side interface (slave modport), see ps2_mouse_device_if
module ps2_mouse_device #(
    parameter int CLK_HALF    = 2000,
    parameter int INHIBIT_MIN = 5000
) (
    input  logic clk,
    input  logic reset,
    inout  wire  ps2c,
    inout  wire  ps2d,
    ps2_mouse_device_if.slave mif
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] INHIB   = 3'd1;
    localparam logic [2:0] RX_WAIT = 3'd2;
    localparam logic [2:0] RX      = 3'd3;
    localparam logic [2:0] TX_BYTE = 3'd4;
    localparam logic [2:0] TX_GAP  = 3'd5;

    localparam int TMAX = (INHIBIT_MIN > 2 * CLK_HALF) ? INHIBIT_MIN : 2 * CLK_HALF;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLK_HALF);
    localparam logic [TW-1:0] T_MID  = TW'(CLK_HALF / 2);
    localparam logic [TW-1:0] T_END  = TW'(2 * CLK_HALF - 1);
    localparam logic [TW-1:0] T_INH  = TW'(INHIBIT_MIN);

    logic [1:0]    c_sync, d_sync;
    logic          c_s, d_s;
    logic [2:0]    state;
    logic [TW-1:0] tmr;
    logic [3:0]    bcnt;
    logic [7:0]    rx_sr;
    logic          rx_par, rx_stop;
    logic [7:0]    tx_byte;
    logic [7:0]    q0, q1, q2;
    logic [1:0]    n_bytes, idx;
    logic          str_next, str_upd, streaming_r;
    logic [7:0]    cmd_data_r;
    logic          cmd_tick_r, err_tick_r;

    logic [10:0]   tx_frame;
    logic          mid, bit_end, c_low, d_low, rx_good;
    logic [7:0]    pkt_b1, q_sel;

    assign c_s = c_sync[1];
    assign d_s = d_sync[1];

    // start, data LSB first, odd parity, stop
    assign tx_frame = {1'b1, ~^tx_byte, tx_byte, 1'b0};
    assign mid      = (tmr == T_MID);
    assign bit_end  = (tmr == T_END);
    assign rx_good  = (^{rx_sr, rx_par}) && rx_stop;
    assign pkt_b1   = {2'b00, mif.y_mov[8], mif.x_mov[8], 1'b1, mif.btn};
    assign q_sel    = (idx == 2'd0) ? q0 : (idx == 2'd1) ? q1 : q2;

    // Line drivers are decoded from registered state so reset releases
    // both lines immediately.
    assign c_low = ((state == TX_BYTE) || (state == RX)) && (tmr >= T_HALF);
    assign d_low = ((state == TX_BYTE) && !tx_frame[bcnt]) ||
                   ((state == RX) && (bcnt == 4'd10));
    assign ps2c  = c_low ? 1'b0 : 1'bz;
    assign ps2d  = d_low ? 1'b0 : 1'bz;

    assign mif.busy      = (state != IDLE);
    assign mif.streaming = streaming_r;
    assign mif.cmd_data  = cmd_data_r;
    assign mif.cmd_tick  = cmd_tick_r;
    assign mif.err_tick  = err_tick_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sync      <= 2'b11;
            d_sync      <= 2'b11;
            state       <= IDLE;
            tmr         <= '0;
            bcnt        <= '0;
            rx_sr       <= '0;
            rx_par      <= 1'b0;
            rx_stop     <= 1'b0;
            tx_byte     <= '0;
            q0          <= '0;
            q1          <= '0;
            q2          <= '0;
            n_bytes     <= '0;
            idx         <= '0;
            str_next    <= 1'b0;
            str_upd     <= 1'b0;
            streaming_r <= 1'b0;
            cmd_data_r  <= '0;
            cmd_tick_r  <= 1'b0;
            err_tick_r  <= 1'b0;
        end else begin
            c_sync     <= {c_sync[0], ps2c};
            d_sync     <= {d_sync[0], ps2d};
            cmd_tick_r <= 1'b0;
            err_tick_r <= 1'b0;
            case (state)
                IDLE, INHIB: begin
                    // tmr measures how long the host has held ps2c low
                    if (!c_s) begin
                        if (tmr < T_INH) tmr <= tmr + 1'b1;
                    end else if ((tmr >= T_INH) && !d_s) begin
                        tmr   <= '0;
                        state <= RX_WAIT;
                    end else begin
                        tmr   <= '0;
                        state <= IDLE;
                        if ((state == IDLE) && mif.pkt_req && streaming_r) begin
                            q0      <= pkt_b1;
                            q1      <= mif.x_mov[7:0];
                            q2      <= mif.y_mov[7:0];
                            tx_byte <= pkt_b1;
                            n_bytes <= 2'd3;
                            idx     <= 2'd0;
                            bcnt    <= '0;
                            str_upd <= 1'b0;
                            state   <= TX_BYTE;
                        end
                    end
                end
                RX_WAIT: begin
                    if (tmr == T_HALF - 1'b1) begin
                        tmr   <= '0;
                        bcnt  <= '0;
                        state <= RX;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                RX: begin
                    tmr <= bit_end ? '0 : tmr + 1'b1;
                    if (mid) begin
                        if (bcnt < 4'd8)       rx_sr   <= {d_s, rx_sr[7:1]};
                        else if (bcnt == 4'd8) rx_par  <= d_s;
                        else if (bcnt == 4'd9) rx_stop <= d_s;
                    end
                    if (bit_end) begin
                        if (bcnt == 4'd10) begin
                            state   <= TX_GAP;
                            idx     <= 2'd0;
                            n_bytes <= 2'd1;
                            q0      <= 8'hFA;
                            str_upd <= 1'b0;
                            if (rx_good) begin
                                cmd_data_r <= rx_sr;
                                cmd_tick_r <= 1'b1;
                                case (rx_sr)
                                    8'hF4: begin str_next <= 1'b1; str_upd <= 1'b1; end
                                    8'hF5: begin str_next <= 1'b0; str_upd <= 1'b1; end
                                    8'hFF: begin
                                        str_next <= 1'b0;
                                        str_upd  <= 1'b1;
                                        q1       <= 8'hAA;
                                        q2       <= 8'h00;
                                        n_bytes  <= 2'd3;
                                    end
                                    default: ;
                                endcase
                            end else begin
                                err_tick_r <= 1'b1;
                                q0         <= 8'hFE;
                            end
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                TX_BYTE: begin
                    tmr <= bit_end ? '0 : tmr + 1'b1;
                    if (mid && !c_s) begin
                        // host inhibit: drop this byte and everything queued
                        tmr        <= '0;
                        str_upd    <= 1'b0;
                        err_tick_r <= 1'b1;
                        state      <= INHIB;
                    end else if (bit_end) begin
                        if (bcnt == 4'd10) begin
                            idx   <= idx + 2'd1;
                            state <= TX_GAP;
                        end else begin
                            bcnt <= bcnt + 1'b1;
                        end
                    end
                end
                TX_GAP: begin
                    if (bit_end) begin
                        tmr <= '0;
                        if (idx == n_bytes) begin
                            state <= IDLE;
                        end else begin
                            tx_byte <= q_sel;
                            bcnt    <= '0;
                            state   <= TX_BYTE;
                            // mode change lands as the first reply byte starts
                            if ((idx == 2'd0) && str_upd) begin
                                streaming_r <= str_next;
                                str_upd     <= 1'b0;
                            end
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_mouse_device.sv
// tb_ps2_mouse_device: host-side model driving ps2_mouse_device through
// command rows (RTS + byte, replies, mode) plus hand-written packet,
// inhibit-abort and reset-mid-RX sequences.
module tb_ps2_mouse_device;
    localparam int CLK_HALF = 4;
    localparam int INH      = 20;
    localparam int SEQ_NONE = 0, SEQ_PKT = 1, SEQ_NOPKT = 2, SEQ_ABORT = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic host_c_low = 1'b0;
    logic host_d_low = 1'b0;
    wire  ps2c, ps2d;

    assign ps2c = host_c_low ? 1'b0 : 1'bz;
    assign ps2d = host_d_low ? 1'b0 : 1'bz;
    pullup (ps2c);
    pullup (ps2d);

    ps2_mouse_device_if mif ();

    ps2_mouse_device #(.CLK_HALF(CLK_HALF), .INHIBIT_MIN(INH)) dut (
        .clk   (clk),
        .reset (reset),
        .ps2c  (ps2c),
        .ps2d  (ps2d),
        .mif   (mif.slave)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;
    int cmd_ticks = 0;
    int err_ticks = 0;
    int falls = 0;
    logic prev_c = 1'b1;

    always @(negedge clk) begin
        if (mif.cmd_tick === 1'b1) cmd_ticks <= cmd_ticks + 1;
        if (mif.err_tick === 1'b1) err_ticks <= err_ticks + 1;
        prev_c <= ps2c;
        if (prev_c === 1'b1 && ps2c === 1'b0) falls <= falls + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        ncmp++;
        nfail++;
        $display("FAIL %s: timed out waiting on the device", name);
    endtask

    task automatic wait_fall(output bit ok);
        logic prev;
        prev = ps2c;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (prev === 1'b1 && ps2c === 1'b0) begin
                ok = 1'b1;
                return;
            end
            prev = ps2c;
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mif.busy === 1'b0) return;
        end
        timeout(name);
    endtask

    // Host-to-device: RTS, then bits changed in each clock-low half.
    task automatic host_send(input logic [7:0] b, input bit bad, input int nfall);
        logic [9:0] bits;
        bit ok;
        bits = {1'b1, (~^b) ^ bad, b};
        @(negedge clk);
        host_c_low = 1'b1;
        repeat (INH + 5) @(negedge clk);
        host_d_low = 1'b1;
        repeat (3) @(negedge clk);
        host_c_low = 1'b0;
        repeat (3) @(negedge clk);
        host_d_low = !bits[0];
        for (int k = 1; k <= nfall; k++) begin
            wait_fall(ok);
            if (!ok) begin
                host_d_low = 1'b0;
                timeout("host_send clock");
                return;
            end
            if (k <= 9) host_d_low = !bits[k];
            if (k == 11) check("line ack", ps2d, 1'b0);
        end
    endtask

    task automatic host_recv(input string name, output logic [7:0] b);
        logic [10:0] fr;
        bit ok;
        fr = '0;
        for (int k = 0; k < 11; k++) begin
            wait_fall(ok);
            if (!ok) begin
                timeout(name);
                b = 8'hxx;
                return;
            end
            fr[k] = ps2d;
        end
        check({name, " frame"}, {fr[0], fr[10], ^fr[9:1]}, 3'b011);
        b = fr[8:1];
    endtask

    task automatic pulse_pkt(input logic [8:0] x, input logic [8:0] y, input logic [2:0] bt);
        mif.x_mov = x;
        mif.y_mov = y;
        mif.btn = bt;
        @(negedge clk);
        mif.pkt_req = 1'b1;
        @(negedge clk);
        mif.pkt_req = 1'b0;
        // inputs must have been captured on the accept cycle
        mif.x_mov = 9'h155;
        mif.y_mov = 9'h0AA;
        mif.btn = 3'b010;
    endtask

    typedef struct {
        logic [7:0]      cmd;
        bit              bad;
        int              nrep;
        logic [2:0][7:0] rep;
        bit              str;
        int              dcmd;
        int              derr;
        int              seq;
    } row_t;

    row_t rows [7];

    initial begin
        logic [7:0] b;
        logic [7:0] exp_cmd;
        int c0, e0, f0;
        bit busy_seen, ok;

        rows[0] = '{8'hF4, 1'b0, 1, {8'h00, 8'h00, 8'hFA}, 1'b1, 1, 0, SEQ_PKT};
        rows[1] = '{8'hFF, 1'b0, 3, {8'h00, 8'hAA, 8'hFA}, 1'b0, 1, 0, SEQ_NOPKT};
        rows[2] = '{8'hF4, 1'b1, 1, {8'h00, 8'h00, 8'hFE}, 1'b0, 0, 1, SEQ_NONE};
        rows[3] = '{8'hF4, 1'b0, 1, {8'h00, 8'h00, 8'hFA}, 1'b1, 1, 0, SEQ_ABORT};
        rows[4] = '{8'hF5, 1'b0, 1, {8'h00, 8'h00, 8'hFA}, 1'b0, 1, 0, SEQ_NONE};
        rows[5] = '{8'hE6, 1'b0, 1, {8'h00, 8'h00, 8'hFA}, 1'b0, 1, 0, SEQ_NONE};
        rows[6] = '{8'hF4, 1'b0, 1, {8'h00, 8'h00, 8'hFA}, 1'b1, 1, 0, SEQ_NONE};

        mif.x_mov = '0;
        mif.y_mov = '0;
        mif.btn = '0;
        mif.pkt_req = 1'b0;
        exp_cmd = 8'h00;

        repeat (5) @(negedge clk);
        check("reset lines", {ps2c, ps2d}, 2'b11);
        check("reset outputs", {mif.busy, mif.streaming, mif.cmd_data, mif.cmd_tick, mif.err_tick}, '0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            c0 = cmd_ticks;
            e0 = err_ticks;
            host_send(rows[i].cmd, rows[i].bad, 11);
            for (int r = 0; r < rows[i].nrep; r++) begin
                host_recv($sformatf("row%0d reply%0d", i, r), b);
                check($sformatf("row%0d reply%0d byte", i, r), b, rows[i].rep[r]);
            end
            wait_idle($sformatf("row%0d idle", i));
            if (rows[i].dcmd != 0) exp_cmd = rows[i].cmd;
            check($sformatf("row%0d streaming", i), mif.streaming, rows[i].str);
            check($sformatf("row%0d cmd_tick count", i), cmd_ticks - c0, rows[i].dcmd);
            check($sformatf("row%0d err_tick count", i), err_ticks - e0, rows[i].derr);
            check($sformatf("row%0d cmd_data", i), mif.cmd_data, exp_cmd);

            case (rows[i].seq)
                SEQ_PKT: begin
                    pulse_pkt(9'h1F0, 9'h005, 3'b001);
                    host_recv("pkt1 b1", b); check("pkt1 b1 byte", b, 8'h19);
                    host_recv("pkt1 b2", b); check("pkt1 b2 byte", b, 8'hF0);
                    host_recv("pkt1 b3", b); check("pkt1 b3 byte", b, 8'h05);
                    wait_idle("pkt1 idle");
                    pulse_pkt(9'h003, 9'h1FE, 3'b110);
                    host_recv("pkt2 b1", b); check("pkt2 b1 byte", b, 8'h2E);
                    host_recv("pkt2 b2", b); check("pkt2 b2 byte", b, 8'h03);
                    host_recv("pkt2 b3", b); check("pkt2 b3 byte", b, 8'hFE);
                    wait_idle("pkt2 idle");
                    check("pkt2 busy", mif.busy, 1'b0);
                end
                SEQ_NOPKT: begin
                    f0 = falls;
                    busy_seen = 1'b0;
                    pulse_pkt(9'h010, 9'h020, 3'b111);
                    for (int k = 0; k < 60; k++) begin
                        @(negedge clk);
                        if (mif.busy !== 1'b0) busy_seen = 1'b1;
                    end
                    check("nopkt busy", busy_seen, 1'b0);
                    check("nopkt clock falls", falls - f0, 0);
                end
                SEQ_ABORT: begin
                    e0 = err_ticks;
                    c0 = cmd_ticks;
                    pulse_pkt(9'h1F0, 9'h005, 3'b001);
                    host_recv("abort b1", b); check("abort b1 byte", b, 8'h19);
                    for (int k = 0; k < 3; k++) begin
                        wait_fall(ok);
                        if (!ok) timeout("abort b2 clock");
                    end
                    for (int k = 0; k < 50 && ps2c !== 1'b1; k++) @(negedge clk);
                    host_c_low = 1'b1;
                    repeat (30) @(negedge clk);
                    check("abort err_tick count", err_ticks - e0, 1);
                    check("abort data released", ps2d, 1'b1);
                    check("abort busy in inhibit", mif.busy, 1'b1);
                    host_c_low = 1'b0;
                    repeat (6) @(negedge clk);
                    check("abort busy after release", mif.busy, 1'b0);
                    f0 = falls;
                    repeat (60) @(negedge clk);
                    check("abort no resume", falls - f0, 0);
                    check("abort cmd_tick count", cmd_ticks - c0, 0);
                end
                default: ;
            endcase
        end

        // reset in the middle of a host-to-device byte
        check("pre-reset streaming", mif.streaming, 1'b1);
        host_send(8'hF4, 1'b0, 4);
        @(negedge clk);
        reset = 1'b0;
        host_d_low = 1'b0;
        #1;
        check("midrx reset lines", {ps2c, ps2d}, 2'b11);
        check("midrx reset outputs", {mif.busy, mif.streaming, mif.cmd_data, mif.cmd_tick, mif.err_tick}, '0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        f0 = falls;
        repeat (40) @(negedge clk);
        check("post-reset idle", {mif.busy, ps2c, ps2d}, 3'b011);
        check("post-reset no clock", falls - f0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d compared so far", ncmp);
        $fatal(1, "watchdog");
    end
endmodule
